// File: rtl/bcd_serial_adder_ctrl.sv
// Multi-digit packed-BCD adder controller: one shared decimal digit stage
// is stepped over the operands, least significant digit first.
module bcd_serial_adder_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   addend,
    input  logic [4*DIGITS-1:0]   augend,
    input  logic                  carry_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  carry_out,
    output logic                  err
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_accept;

    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_acc;
    logic [W-1:0]    r_sum;
    logic [IW-1:0]   r_idx;
    logic            r_c;
    logic            r_err_acc;
    logic            r_cout;
    logic            r_err;

    logic            w_last;
    logic [3:0]      w_da;
    logic [3:0]      w_db;
    logic [4:0]      w_t;
    logic [3:0]      w_tc;
    logic [3:0]      w_digit;
    logic            w_c;
    logic            w_bad;
    logic [W-1:0]    w_acc_nxt;

    assign w_last = (r_idx == LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_accept    = 1'b1;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Single decimal digit stage; (t+6) mod 16 is all that survives.
    always_comb begin
        w_da      = r_a[{r_idx, 2'b00} +: 4];
        w_db      = r_b[{r_idx, 2'b00} +: 4];
        w_t       = {1'b0, w_da} + {1'b0, w_db} + {4'b0000, r_c};
        w_tc      = w_t[3:0] + 4'd6;
        w_digit   = w_t[3:0];
        w_c       = 1'b0;
        if (w_t > 5'd9) begin
            w_digit = w_tc;
            w_c     = 1'b1;
        end
        w_bad     = (w_da > 4'd9) || (w_db > 4'd9);
        w_acc_nxt = r_acc;
        w_acc_nxt[{r_idx, 2'b00} +: 4] = w_digit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_sum     <= '0;
            r_idx     <= '0;
            r_c       <= 1'b0;
            r_err_acc <= 1'b0;
            r_cout    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a       <= addend;
                r_b       <= augend;
                r_c       <= carry_in;
                r_idx     <= '0;
                r_acc     <= '0;
                r_err_acc <= 1'b0;
            end else if (r_state == S_RUN) begin
                r_acc     <= w_acc_nxt;
                r_c       <= w_c;
                r_err_acc <= r_err_acc | w_bad;
                r_idx     <= r_idx + 1'b1;
                // Commit on the edge that enters DONE.
                if (w_last) begin
                    r_sum  <= w_acc_nxt;
                    r_cout <= w_c;
                    r_err  <= r_err_acc | w_bad;
                end
            end
        end
    end

    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign sum       = r_sum;
    assign carry_out = r_cout;
    assign err       = r_err;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Randomised self-checking bench for bcd_serial_adder_ctrl; expected results
// come from decimal integer arithmetic on the decoded operands.
module tb_bcd_serial_adder_ctrl;

    localparam int D = 4;
    localparam int W = 4 * D;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] addend;
    logic [W-1:0] augend;
    logic         carry_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         err;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_serial_adder_ctrl #(.DIGITS(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .addend    (addend),
        .augend    (augend),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decimal reference: decode, add as integers, re-encode.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, output logic [W-1:0] s,
                         output logic c, output logic e);
        int va, vb, v, p, da, db;
        va = 0; vb = 0; p = 1; e = 1'b0; s = '0;
        for (int i = 0; i < D; i++) begin
            da = int'(a[4*i +: 4]);
            db = int'(b[4*i +: 4]);
            if (da > 9 || db > 9) e = 1'b1;
            va += da * p;
            vb += db * p;
            p  *= 10;
        end
        v = va + vb + int'(cin);
        c = (v >= p);
        v = v % p;
        for (int i = 0; i < D; i++) begin
            s[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int k = 1; k <= D + 4; k++) begin
            if (n < 0) begin
                @(posedge clk); #1;
                if (done) n = k;
            end
        end
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic cin);
        logic [W-1:0] es;
        logic ec, ee;
        model(a, b, cin, es, ec, ee);
        check({tag, "_busy_at_done"}, busy, 1'b0);
        check({tag, "_err"}, err, ee);
        if (!ee) begin
            check({tag, "_sum"}, sum, es);
            check({tag, "_cout"}, carry_out, ec);
        end
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin);
        int n;
        start = 1'b1; addend = a; augend = b; carry_in = cin;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, busy, 1'b1);
        wait_done(n);
        check({tag, "_latency"}, 64'(n), 64'(D));
        check_result(tag, a, b, cin);
    endtask

    function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
        logic [W-1:0] v;
        for (int i = 0; i < D; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        if (allow_bad && $urandom_range(0, 7) == 0)
            v[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
        return v;
    endfunction

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0;
        addend = '0; augend = '0; carry_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("idle_busy", busy, 1'b0);
            check("idle_done", done, 1'b0);
        end
        check("idle_sum", sum, '0);
        check("idle_cout", carry_out, 1'b0);
        check("idle_err", err, 1'b0);

        do_op("ripple", 16'h9999, 16'h0001, 1'b0);
        check("ripple_sum_k", sum, 16'h0000);
        check("ripple_cout_k", carry_out, 1'b1);
        do_op("mix1", 16'h1234, 16'h8766, 1'b0);
        check("mix1_cout_k", carry_out, 1'b1);
        do_op("mix2", 16'h0456, 16'h0123, 1'b1);
        check("mix2_sum_k", sum, 16'h0580);
        do_op("bad", 16'h00A0, 16'h0000, 1'b0);
        check("bad_err_k", err, 1'b1);
        do_op("clr", 16'h0011, 16'h0022, 1'b0);
        check("clr_err_k", err, 1'b0);

        // Mid-RUN start and operand changes must be ignored.
        start = 1'b1; addend = 16'h2718; augend = 16'h3141; carry_in = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; addend = 16'h9999; augend = 16'h9999; carry_in = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("hs_busy_mid", busy, 1'b1);
        wait_done(n);
        check("hs_latency", 64'(n), 64'(D - 2));
        check("hs_sum", sum, 16'h5859);
        check("hs_cout", carry_out, 1'b0);
        // Back-to-back acceptance from DONE.
        start = 1'b1; addend = 16'h4321; augend = 16'h1234; carry_in = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy", busy, 1'b1);
        check("b2b_done", done, 1'b0);
        wait_done(n);
        check("b2b_latency", 64'(n), 64'(D));
        check("b2b_sum", sum, 16'h5556);

        // Asynchronous reset in the second RUN cycle.
        start = 1'b1; addend = 16'h9999; augend = 16'h0001; carry_in = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sum", sum, '0);
        check("rst_cout", carry_out, 1'b0);
        check("rst_err", err, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < D + 2; k++) begin
            @(posedge clk); #1;
            check("rst_no_done", done, 1'b0);
        end
        do_op("after_rst", 16'h0808, 16'h0303, 1'b1);

        for (int k = 0; k < 40; k++) begin
            do_op("rand", rand_bcd(1'b1), rand_bcd(1'b1),
                  1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
